mix_engine: RTL and testbench
=============================

MIX_ENGINE -- requirements
Module: mix_engine

Interface
REQ-001 SHALL have parameter NCH, default 4: number of mix channels, 2..8.
REQ-002 SHALL have parameter AW, default 23: SDRAM word-address width.
REQ-003 SHALL have parameter INTERP, default 2: number of audio handshakes per mixed frame, 1..8.
REQ-004 SHALL have parameter GW, default 3: per-channel attenuation shift width.
REQ-005 SHALL have port i_clk, in, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n, in, 1: asynchronous active-low reset.
REQ-007 SHALL have port start_valid, in, 1: one-cycle request to arm channel start_ch.
REQ-008 SHALL have port start_ch, in, clog2(NCH): channel to arm.
REQ-009 SHALL have port start_addr, in, AW: header word address; sample data begins at start_addr+1.
REQ-010 SHALL have port gain, in, NCH*GW: arithmetic right-shift amount for channel c, taken from bits [c*GW +: GW].
REQ-011 SHALL have port stop, in, 1: abort all channels.
REQ-012 SHALL have port ch_active, out, NCH: channel c is playing.
REQ-013 SHALL have port done, out, 1: one-cycle end-of-mix pulse.
REQ-014 SHALL have ports mem_read (out, 1), mem_addr (out, AW), mem_readdata (in, 32) and mem_finished (in, 1): SDRAM read port.
REQ-015 SHALL have ports aud_valid (out, 1), aud_data (out, 32) and aud_ready (in, 1): stereo sample output, left in [31:16] and right in [15:0], both signed.

Function
REQ-016 SHALL implement exactly these states: IDLE, HDR, FETCH, SUM, PLAY.
REQ-017 SHALL, on start_valid, set pending bit start_ch in any state; re-arming an active channel SHALL restart it.
REQ-018 SHALL move from IDLE, or at exit from PLAY, to HDR when any pending bit is set; otherwise IDLE SHALL stay in IDLE and PLAY SHALL go to FETCH.
REQ-019 SHALL, in HDR, read the header of the lowest-index pending channel, set end[c] = start_addr + 1 + readdata[AW-1:0] and rd[c] = start_addr + 1, clear the pending bit, and set ch_active[c] only when length is nonzero.
REQ-020 SHALL leave HDR to FETCH when no pending bits remain; otherwise it SHALL read the next pending header.
REQ-021 SHALL, in FETCH, visit channels 0..NCH-1 one per step: an active channel is read at rd[c] and rd[c] increments; an inactive channel contributes zero with no read, taking one cycle.
REQ-022 SHALL clear ch_active[c] when rd[c] reaches end[c] after an increment; the sample just read is still mixed.
REQ-023 SHALL hold mem_read high and mem_addr stable from request until the cycle mem_finished=1, sampling mem_readdata in that cycle.
REQ-024 SHALL, in SUM (one cycle), form each lane as the sum over c of (lane_c >>> gain_c), computed at 16+clog2(NCH) bits and saturated to [-32768, 32767] before registering to aud_data.
REQ-025 SHALL, in PLAY, hold aud_valid=1 with aud_data stable and count handshakes (aud_valid & aud_ready); after INTERP handshakes it SHALL leave PLAY.
REQ-026 SHALL, at exit from SUM, go to IDLE and pulse done for one cycle if no channel was active at FETCH entry and none is pending; the all-zero frame SHALL NOT be played.
REQ-027 SHALL, on stop, go to IDLE next cycle from any state, clear ch_active, pending bits and the handshake counter, deassert mem_read, and pulse done; stop SHALL win over a simultaneous start_valid.
REQ-028 SHALL, on a stop during an SDRAM read, abandon the read and ignore a later mem_finished.
REQ-029 SHALL let rd and end wrap modulo 2^AW.
REQ-030 SHALL compare end addresses for equality only.

Reset
REQ-031 SHALL, while i_rst_n=0, force state IDLE and all of mem_read, mem_addr, aud_valid, aud_data, done and ch_active to 0, and clear all pending, rd, end and counter registers.
REQ-032 SHALL make the first request possible only from the first rising edge after i_rst_n deasserts.
REQ-033 SHALL, on reset assertion mid-transfer, abort without completing any handshake.

Verification
REQ-034 SHALL cover: arm ch0 with header 3 and samples 0x00100020, 0x00300040, 0x00500060, INTERP=2, gain 0 -> three frames each delivered twice, then done pulse, ch_active=0.
REQ-035 SHALL cover: ch0 and ch1 both with left sample 0x7000, gain 0 -> left lane 0x7FFF (saturated); both with left 0x9000 -> left lane 0x8000.
REQ-036 SHALL cover: gain ch2=2 with sample 0x0100FF00 alone -> aud_data 0x0040FFC0.
REQ-037 SHALL cover: arm ch1 while ch0 is mid-play -> HDR entered after the current PLAY, ch0 sample sequence unbroken, and frames thereafter sum both channels.
REQ-038 SHALL cover: stop asserted while mem_read=1 and start_valid in the same cycle -> IDLE next cycle, done=1 for one cycle, ch_active=0, and a late mem_finished has no effect.
REQ-039 SHALL cover: header length 0 -> ch_active stays 0 and done pulses after one SUM.

Source files
------------

// File: rtl/mix_engine.sv
// mix_engine: multi-channel SDRAM sample mixer.
// Each armed channel owns a header word (sample count) followed by packed
// stereo samples. Every frame fetches one sample per active channel,
// attenuates each lane by its channel's shift, sums with saturation and
// presents the result for INTERP audio handshakes.
module mix_engine #(
    parameter int NCH    = 4,
    parameter int AW     = 23,
    parameter int INTERP = 2,
    parameter int GW     = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     start_valid,
    input  logic [$clog2(NCH)-1:0]   start_ch,
    input  logic [AW-1:0]            start_addr,
    input  logic [NCH*GW-1:0]        gain,
    input  logic                     stop,
    output logic [NCH-1:0]           ch_active,
    output logic                     done,
    output logic                     mem_read,
    output logic [AW-1:0]            mem_addr,
    input  logic [31:0]              mem_readdata,
    input  logic                     mem_finished,
    output logic                     aud_valid,
    output logic [31:0]              aud_data,
    input  logic                     aud_ready
);

    localparam int CW = $clog2(NCH);
    localparam int SW = 16 + CW;
    localparam int HW = 4;
    localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        SUM   = 3'd3,
        PLAY  = 3'd4
    } state_t;

    state_t            r_state;
    logic [NCH-1:0]    r_pending;
    logic [NCH-1:0]    r_ch_active;
    logic [AW-1:0]     r_saddr [NCH];
    logic [AW-1:0]     r_rd    [NCH];
    logic [AW-1:0]     r_end   [NCH];
    logic [31:0]       r_samp  [NCH];
    logic [CW-1:0]     r_idx;
    logic [CW-1:0]     r_cur;
    logic [HW-1:0]     r_hs;
    logic              r_any_act;
    logic              r_mem_read;
    logic [AW-1:0]     r_mem_addr;
    logic              r_aud_valid;
    logic [31:0]       r_aud_data;
    logic              r_done;

    logic [NCH-1:0]    w_set;
    logic [NCH-1:0]    w_cur_mask;
    logic [NCH-1:0]    w_pend_after_hdr;
    logic [CW-1:0]     w_low;
    logic signed [SW-1:0] w_acc_l;
    logic signed [SW-1:0] w_acc_r;
    logic [31:0]       w_mix;

    // Sign-extend one 16-bit lane to the accumulator width and attenuate it.
    function automatic logic signed [SW-1:0] f_lane(input logic [15:0] s, input logic [GW-1:0] g);
        logic signed [SW-1:0] e;
        e = {{(SW-16){s[15]}}, s};
        return e >>> g;
    endfunction

    // Clamp an accumulated lane to the signed 16-bit range.
    function automatic logic [15:0] f_sat(input logic signed [SW-1:0] v);
        logic [15:0] res;
        if (v > SAT_MAX) begin
            res = 16'h7FFF;
        end else if (v < SAT_MIN) begin
            res = 16'h8000;
        end else begin
            res = v[15:0];
        end
        return res;
    endfunction

    assign ch_active = r_ch_active;
    assign done      = r_done;
    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign aud_valid = r_aud_valid;
    assign aud_data  = r_aud_data;

    // One-hot masks for a new arm request and the header currently in flight.
    always_comb begin
        w_set      = '0;
        w_cur_mask = '0;
        if (start_valid) begin
            w_set[start_ch] = 1'b1;
        end else begin
            w_set = '0;
        end
        w_cur_mask[r_cur] = 1'b1;
        w_pend_after_hdr  = (r_pending & ~w_cur_mask) | w_set;
    end

    // Lowest-index pending channel gets its header serviced first.
    always_comb begin
        w_low = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            w_low = r_pending[c] ? CW'(c) : w_low;
        end
    end

    // Attenuate and sum every channel's latched sample, then saturate per lane.
    always_comb begin
        w_acc_l = '0;
        w_acc_r = '0;
        for (int c = 0; c < NCH; c++) begin
            w_acc_l = w_acc_l + f_lane(r_samp[c][31:16], gain[c*GW +: GW]);
            w_acc_r = w_acc_r + f_lane(r_samp[c][15:0],  gain[c*GW +: GW]);
        end
        w_mix = {f_sat(w_acc_l), f_sat(w_acc_r)};
    end

    // Control FSM with all datapath registers; stop overrides everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_ch_active <= '0;
            r_idx       <= '0;
            r_cur       <= '0;
            r_hs        <= '0;
            r_any_act   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_aud_valid <= 1'b0;
            r_aud_data  <= 32'h0000_0000;
            r_done      <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_saddr[c] <= '0;
                r_rd[c]    <= '0;
                r_end[c]   <= '0;
                r_samp[c]  <= 32'h0000_0000;
            end
        end else if (stop) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_ch_active <= '0;
            r_idx       <= '0;
            r_hs        <= '0;
            r_any_act   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_aud_valid <= 1'b0;
            r_done      <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_pending <= r_pending | w_set;
            if (start_valid) begin
                r_saddr[start_ch] <= start_addr;
            end
            case (r_state)
                IDLE: begin
                    if (|(r_pending | w_set)) begin
                        r_state <= HDR;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HDR: begin
                    if (!r_mem_read) begin
                        r_cur      <= w_low;
                        r_mem_read <= 1'b1;
                        r_mem_addr <= r_saddr[w_low];
                    end else if (mem_finished) begin
                        r_mem_read         <= 1'b0;
                        r_rd[r_cur]        <= r_mem_addr + AW'(1);
                        r_end[r_cur]       <= r_mem_addr + AW'(1) + mem_readdata[AW-1:0];
                        r_ch_active[r_cur] <= |mem_readdata[AW-1:0];
                        r_pending          <= w_pend_after_hdr;
                        if (|w_pend_after_hdr) begin
                            r_state <= HDR;
                        end else begin
                            r_state   <= FETCH;
                            r_idx     <= '0;
                            r_any_act <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (!r_mem_read) begin
                        r_any_act <= r_any_act | r_ch_active[r_idx];
                        if (r_ch_active[r_idx]) begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= r_rd[r_idx];
                        end else begin
                            r_samp[r_idx] <= 32'h0000_0000;
                            if (r_idx == CW'(NCH - 1)) begin
                                r_idx   <= '0;
                                r_state <= SUM;
                            end else begin
                                r_idx <= r_idx + CW'(1);
                            end
                        end
                    end else if (mem_finished) begin
                        r_mem_read    <= 1'b0;
                        r_samp[r_idx] <= mem_readdata;
                        r_rd[r_idx]   <= r_rd[r_idx] + AW'(1);
                        if ((r_rd[r_idx] + AW'(1)) == r_end[r_idx]) begin
                            r_ch_active[r_idx] <= 1'b0;
                        end
                        if (r_idx == CW'(NCH - 1)) begin
                            r_idx   <= '0;
                            r_state <= SUM;
                        end else begin
                            r_idx <= r_idx + CW'(1);
                        end
                    end
                end
                SUM: begin
                    r_aud_data <= w_mix;
                    if (!r_any_act && (r_pending == '0)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= PLAY;
                        r_aud_valid <= 1'b1;
                        r_hs        <= '0;
                    end
                end
                PLAY: begin
                    if (aud_ready) begin
                        if (r_hs == HW'(INTERP - 1)) begin
                            r_hs        <= '0;
                            r_aud_valid <= 1'b0;
                            if (|(r_pending | w_set)) begin
                                r_state <= HDR;
                            end else begin
                                r_state   <= FETCH;
                                r_idx     <= '0;
                                r_any_act <= 1'b0;
                            end
                        end else begin
                            r_hs <= r_hs + HW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_aud_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_engine.sv
// Self-checking bench for mix_engine: SDRAM responder with random latency,
// audio sink with random ready, and a scoreboard of expected mixed frames.
module tb_mix_engine;

    logic        i_clk;
    logic        i_rst_n;
    logic        start_valid;
    logic [1:0]  start_ch;
    logic [22:0] start_addr;
    logic [11:0] gain;
    logic        stop;
    logic [3:0]  ch_active;
    logic        done;
    logic        mem_read;
    logic [22:0] mem_addr;
    logic [31:0] mem_readdata;
    logic        mem_finished;
    logic        aud_valid;
    logic [31:0] aud_data;
    logic        aud_ready;

    logic [31:0] mem [256];
    logic [31:0] sb [$];
    int          n_vec;
    int          n_err;
    int          done_cnt;
    bit          done_prev;
    bit          mem_en;
    int          lat;

    mix_engine #(.NCH(4), .AW(23), .INTERP(2), .GW(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .start_valid(start_valid), .start_ch(start_ch), .start_addr(start_addr),
        .gain(gain), .stop(stop), .ch_active(ch_active), .done(done),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_readdata(mem_readdata),
        .mem_finished(mem_finished),
        .aud_valid(aud_valid), .aud_data(aud_data), .aud_ready(aud_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Independent reference mix: per-lane arithmetic shift, integer sum, clamp.
    function automatic logic [31:0] model_mix(input logic [31:0] s0, input logic [31:0] s1,
                                              input logic [31:0] s2, input logic [31:0] s3,
                                              input logic [11:0] g);
        logic [31:0] sa [4];
        int l;
        int r;
        int v;
        sa[0] = s0; sa[1] = s1; sa[2] = s2; sa[3] = s3;
        l = 0;
        r = 0;
        for (int c = 0; c < 4; c++) begin
            v = $signed(sa[c][31:16]);
            l = l + (v >>> g[c*3 +: 3]);
            v = $signed(sa[c][15:0]);
            r = r + (v >>> g[c*3 +: 3]);
        end
        if (l > 32767) l = 32767;
        if (l < -32768) l = -32768;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return {l[15:0], r[15:0]};
    endfunction

    // SDRAM responder: completes each read after 0..2 extra cycles.
    initial begin
        mem_finished = 1'b0;
        mem_readdata = 32'h0;
        lat = 0;
        forever begin
            @(negedge i_clk);
            if (mem_finished) begin
                mem_finished = 1'b0;
            end else if (mem_en && mem_read === 1'b1) begin
                if (lat == 0) begin
                    mem_finished = 1'b1;
                    mem_readdata = mem[mem_addr[7:0]];
                    lat = $urandom_range(0, 2);
                end else begin
                    lat = lat - 1;
                end
            end
        end
    end

    // Audio sink / scoreboard: a handshake is committed when valid and ready meet.
    initial begin
        logic [31:0] exp_w;
        aud_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            aud_ready = ($urandom_range(0, 3) != 0);
            if (aud_valid === 1'b1 && aud_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL aud_unexpected: got %h, expected no frame", aud_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (aud_data !== exp_w) begin
                        n_err++;
                        $display("FAIL aud_data: got %h, expected %h", aud_data, exp_w);
                    end
                end
            end
        end
    end

    // Done-pulse monitor: counts pulses and flags any pulse wider than one cycle.
    initial begin
        done_cnt  = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (done === 1'b1) begin
                done_cnt++;
                n_vec++;
                if (done_prev) begin
                    n_err++;
                    $display("FAIL done_width: got 2+ cycles, expected 1");
                end
            end
            done_prev = (done === 1'b1);
        end
    end

    task automatic arm(input logic [1:0] ch, input logic [22:0] a);
        @(negedge i_clk);
        start_valid = 1'b1;
        start_ch    = ch;
        start_addr  = a;
        @(negedge i_clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt != d0) break;
            @(negedge i_clk);
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        n_vec += 5;
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b, expected 0", mem_read); end
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL rst_aud_valid: got %b, expected 0", aud_valid); end
        if (aud_data !== 32'h0) begin n_err++; $display("FAIL rst_aud_data: got %h, expected 0", aud_data); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, expected 0", done); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL rst_ch_active: got %h, expected 0", ch_active); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        n_vec += 2;
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL idle_mem_read: got %b, expected 0", mem_read); end
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL idle_aud_valid: got %b, expected 0", aud_valid); end
    endtask

    task automatic test_single();
        int d0;
        bit ok;
        mem[16] = 32'd3;
        mem[17] = 32'h00100020;
        mem[18] = 32'h00300040;
        mem[19] = 32'h00500060;
        gain = 12'h000;
        repeat (2) sb.push_back(32'h00100020);
        repeat (2) sb.push_back(32'h00300040);
        repeat (2) sb.push_back(32'h00500060);
        d0 = done_cnt;
        arm(2'd0, 23'd16);
        wait_done(d0, ok);
        n_vec += 3;
        if (!ok) begin n_err++; $display("FAIL single_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL single_frames: got %0d undelivered, expected 0", sb.size()); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL single_active: got %h, expected 0", ch_active); end
    endtask

    task automatic test_saturate();
        int d0;
        bit ok;
        mem[32] = 32'd1; mem[33] = 32'h70000000;
        mem[40] = 32'd1; mem[41] = 32'h70000000;
        gain = 12'h000;
        repeat (2) sb.push_back(32'h7FFF0000);
        d0 = done_cnt;
        arm(2'd0, 23'd32);
        arm(2'd1, 23'd40);
        wait_done(d0, ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL sat_pos_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL sat_pos_frames: got %0d undelivered, expected 0", sb.size()); end
        mem[33] = 32'h90000000;
        mem[41] = 32'h90000000;
        repeat (2) sb.push_back(32'h80000000);
        d0 = done_cnt;
        arm(2'd1, 23'd40);
        arm(2'd0, 23'd32);
        wait_done(d0, ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL sat_neg_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL sat_neg_frames: got %0d undelivered, expected 0", sb.size()); end
    endtask

    task automatic test_gain();
        int d0;
        bit ok;
        mem[48] = 32'd1; mem[49] = 32'h0100FF00;
        gain = 12'h080;
        repeat (2) sb.push_back(32'h0040FFC0);
        d0 = done_cnt;
        arm(2'd2, 23'd48);
        wait_done(d0, ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL gain_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL gain_frames: got %0d undelivered, expected 0", sb.size()); end
        gain = 12'h000;
    endtask

    task automatic test_rearm_mid();
        int d0;
        int k;
        bit ok;
        mem[64] = 32'd4;
        mem[65] = 32'h00010002; mem[66] = 32'h00030004;
        mem[67] = 32'h00050006; mem[68] = 32'h00070008;
        mem[72] = 32'd2;
        mem[73] = 32'h01000200; mem[74] = 32'h03000400;
        gain = 12'h000;
        repeat (2) sb.push_back(model_mix(mem[65], 32'h0, 32'h0, 32'h0, gain));
        repeat (2) sb.push_back(model_mix(mem[66], mem[73], 32'h0, 32'h0, gain));
        repeat (2) sb.push_back(model_mix(mem[67], mem[74], 32'h0, 32'h0, gain));
        repeat (2) sb.push_back(model_mix(mem[68], 32'h0, 32'h0, 32'h0, gain));
        d0 = done_cnt;
        arm(2'd0, 23'd64);
        k = 0;
        while (aud_valid !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
        start_valid = 1'b1;
        start_ch    = 2'd1;
        start_addr  = 23'd72;
        @(negedge i_clk);
        start_valid = 1'b0;
        k = 0;
        while (aud_valid === 1'b1 && k < 200) begin @(negedge i_clk); k++; end
        k = 0;
        while (mem_read !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
        n_vec++;
        if (mem_addr !== 23'd72) begin n_err++; $display("FAIL rearm_hdr_addr: got %0d, expected 72", mem_addr); end
        wait_done(d0, ok);
        n_vec += 3;
        if (!ok) begin n_err++; $display("FAIL rearm_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL rearm_frames: got %0d undelivered, expected 0", sb.size()); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL rearm_active: got %h, expected 0", ch_active); end
    endtask

    task automatic test_stop();
        int d0;
        int k;
        bit seen;
        mem_en = 1'b0;
        mem[80] = 32'd5;
        d0 = done_cnt;
        arm(2'd0, 23'd80);
        k = 0;
        while (mem_read !== 1'b1 && k < 50) begin @(negedge i_clk); k++; end
        stop        = 1'b1;
        start_valid = 1'b1;
        start_ch    = 2'd1;
        start_addr  = 23'd88;
        @(negedge i_clk);
        stop        = 1'b0;
        start_valid = 1'b0;
        n_vec += 4;
        if (done !== 1'b1) begin n_err++; $display("FAIL stop_done: got %b, expected 1", done); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL stop_active: got %h, expected 0", ch_active); end
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL stop_mem_read: got %b, expected 0", mem_read); end
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL stop_aud_valid: got %b, expected 0", aud_valid); end
        @(negedge i_clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL stop_done_clear: got %b, expected 0", done); end
        #1;
        mem_readdata = 32'd5;
        mem_finished = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge i_clk);
            if (mem_read === 1'b1 || aud_valid === 1'b1 || ch_active !== 4'h0) seen = 1'b1;
        end
        n_vec += 2;
        if (seen) begin n_err++; $display("FAIL stop_late_finish: got activity, expected idle"); end
        if (done_cnt != d0 + 1) begin n_err++; $display("FAIL stop_done_count: got %0d, expected %0d", done_cnt - d0, 1); end
        mem_en = 1'b1;
    endtask

    task automatic test_zero_len();
        int d0;
        bit ok;
        mem[96] = 32'd0;
        d0 = done_cnt;
        arm(2'd3, 23'd96);
        wait_done(d0, ok);
        n_vec += 3;
        if (!ok) begin n_err++; $display("FAIL zero_done: got timeout, expected done pulse"); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL zero_active: got %h, expected 0", ch_active); end
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL zero_aud_valid: got %b, expected 0", aud_valid); end
    endtask

    task automatic test_wrap();
        int d0;
        bit ok;
        mem[8'hFE] = 32'd3;
        mem[8'hFF] = 32'h11112222;
        mem[8'h00] = 32'h33334444;
        mem[8'h01] = 32'h55556666;
        gain = 12'h000;
        repeat (2) sb.push_back(32'h11112222);
        repeat (2) sb.push_back(32'h33334444);
        repeat (2) sb.push_back(32'h55556666);
        d0 = done_cnt;
        arm(2'd0, 23'h7FFFFE);
        wait_done(d0, ok);
        n_vec += 3;
        if (!ok) begin n_err++; $display("FAIL wrap_done: got timeout, expected done pulse"); end
        if (sb.size() != 0) begin n_err++; $display("FAIL wrap_frames: got %0d undelivered, expected 0", sb.size()); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL wrap_active: got %h, expected 0", ch_active); end
    endtask

    task automatic test_reset_mid();
        int k;
        repeat (2) sb.push_back(32'h00100020);
        repeat (2) sb.push_back(32'h00300040);
        repeat (2) sb.push_back(32'h00500060);
        arm(2'd0, 23'd16);
        k = 0;
        while (aud_valid !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL rmid_aud_valid: got %b, expected 0", aud_valid); end
        if (aud_data !== 32'h0) begin n_err++; $display("FAIL rmid_aud_data: got %h, expected 0", aud_data); end
        if (ch_active !== 4'h0) begin n_err++; $display("FAIL rmid_active: got %h, expected 0", ch_active); end
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_mem_read: got %b, expected 0", mem_read); end
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        n_vec += 2;
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_idle_read: got %b, expected 0", mem_read); end
        if (aud_valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle_valid: got %b, expected 0", aud_valid); end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        mem_en      = 1'b1;
        i_rst_n     = 1'b0;
        start_valid = 1'b0;
        start_ch    = 2'd0;
        start_addr  = 23'd0;
        gain        = 12'h000;
        stop        = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        repeat (3) @(negedge i_clk);
        test_reset();
        test_single();
        test_saturate();
        test_gain();
        test_rearm_mid();
        test_stop();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
